pulse_switch_sequencer: RTL
===========================

# pulse_switch_sequencer

Digital sequencer for a capacitive-discharge transient pulse generator. It drives the charge switch (S1, source to storage capacitor) and the discharge switch (S2, capacitor to DUT path) with guaranteed break-before-make dead time, programmable fire width, recharge time and burst count. It sits between the test-control register block and the switch gate drivers. It is the only agent allowed to toggle either switch.

## Interface
Parameters:
- CNT_W, 16, width of all dwell-time config fields (clock cycles)
- BURST_W, 8, width of burst count and pulse counter

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a burst; honoured only in IDLE
- abort  in  1  level or pulse; forces safe shutdown from any active state
- cfg_dead  in  CNT_W  break-before-make dead time; 0 treated as 1
- cfg_fire  in  CNT_W  S2 on-time per pulse; 0 is a config error
- cfg_charge  in  CNT_W  S1 recharge time between pulses; 0 treated as 1
- cfg_burst  in  BURST_W  pulses per burst; 0 is a config error
- s1_on  out  1  charge switch gate, registered
- s2_on  out  1  discharge switch gate, registered
- busy  out  1  high in every state except IDLE and INIT
- pulse_cnt  out  BURST_W  pulses fired in current or last burst
- done  out  1  one-cycle strobe on normal burst completion
- aborted  out  1  one-cycle strobe on abort completion
- err_cfg  out  1  one-cycle strobe when start is rejected

## Operation
- States: INIT, IDLE, BREAK, FIRE, MAKE, RECHARGE.
- Switch outputs per state:
  - INIT: s1=0, s2=0
  - IDLE: s1=1, s2=0 (capacitor held charged)
  - BREAK: s1=0, s2=0
  - FIRE: s1=0, s2=1
  - MAKE: s1=0, s2=0
  - RECHARGE: s1=1, s2=0
- Safety invariant: s1_on && s2_on is never true on any cycle, including reset entry/exit and abort.
- INIT -> IDLE unconditionally one cycle after reset release.
- IDLE + start: latch all cfg_* into shadow registers and clear pulse_cnt.
  - If cfg_fire==0 or cfg_burst==0: strobe err_cfg and stay in IDLE.
  - Otherwise go to BREAK.
- Config inputs are ignored outside IDLE; only shadow values are used.
- BREAK (D cycles) -> FIRE. pulse_cnt increments on FIRE entry; saturates at all-ones, which cannot occur because cfg_burst is bounded.
- FIRE (F cycles) -> MAKE (D cycles) -> RECHARGE (C cycles).
- At RECHARGE end: if pulse_cnt < shadow burst, go to BREAK; else go to IDLE and strobe done.
- Dwell values: D = max(cfg_dead,1), F = cfg_fire, C = max(cfg_charge,1). Per-pulse period is 2D+F+C cycles.
- abort in BREAK, FIRE or RECHARGE: go to MAKE with a fresh D count. At MAKE end go to IDLE and strobe aborted; done is not strobed.
- abort while already in MAKE: MAKE completes normally, then goes to IDLE with aborted.
- abort in IDLE or INIT has no effect.
- abort has priority over timer expiry on the same cycle.
- start while busy is ignored with no error strobe. start and abort together in IDLE: abort ignored, start honoured.

## Timing
- Reset (async assert): state=INIT; s1_on=0, s2_on=0, busy=0, pulse_cnt=0, done=0, aborted=0, err_cfg=0.
- Outputs are registered. start sampled at edge k drives s1_on=0 from cycle k+1.
- Every state lasts exactly its dwell count in cycles, measured from the first cycle the state is visible on the outputs.
- done, aborted and err_cfg are high for exactly one cycle, coincident with the first IDLE cycle (or the rejecting cycle for err_cfg).
- Dwell counters are CNT_W wide, load N-1 on state entry and exit on reaching 0. No wrap-around is possible.

## Structure
- Shared package pulse_seq_pkg:
  - state enum (3-bit, INIT=0)
  - per-state switch encoding constants
  - CNT_W/BURST_W defaults
- Sub-module seq_dwell_timer:
  - loadable CNT_W down-counter with load, value and expire ports
  - single instance, reloaded on every state transition
- Top level holds the FSM, shadow config registers, pulse counter and output registers.

## Test plan
- D=2, F=5, C=10, N=1, start at cycle 0:
  - s1 low cycles 1–9, s2 high cycles 3–7, s1 high from cycle 10
  - done at cycle 20; busy high cycles 1–19
- N=3 with the same timing: three s2 pulses of 5 cycles on a 19-cycle period; pulse_cnt steps 1, 2, 3; single done.
- cfg_dead=0, cfg_charge=0: one-cycle BREAK, MAKE and RECHARGE gaps; assert s1&&s2 never true.
- cfg_fire=0, then cfg_burst=0: err_cfg strobe each time, busy stays 0, switches stay at IDLE values.
- abort in the third FIRE cycle (D=4): s2 low next cycle, D=4 both-off cycles, then IDLE; aborted strobe, no done.
- rst_n asserted mid-FIRE: s2_on=0 asynchronously; after release, one INIT cycle with both off, then s1_on=1.

Source files
------------

// File: rtl/pulse_seq_pkg.sv
// Shared types and constants for the pulse switch sequencer: FSM states,
// per-state switch gate encoding and default field widths.
package pulse_seq_pkg;

   localparam int unsigned CNT_W_DEF   = 16;
   localparam int unsigned BURST_W_DEF = 8;

   typedef enum logic [2:0] {
      ST_INIT     = 3'd0,
      ST_IDLE     = 3'd1,
      ST_BREAK    = 3'd2,
      ST_FIRE     = 3'd3,
      ST_MAKE     = 3'd4,
      ST_RECHARGE = 3'd5
   } state_t;

   typedef struct packed {
      logic s1;
      logic s2;
   } sw_t;

   localparam sw_t SW_OFF    = '{s1: 1'b0, s2: 1'b0};
   localparam sw_t SW_CHARGE = '{s1: 1'b1, s2: 1'b0};
   localparam sw_t SW_FIRE   = '{s1: 1'b0, s2: 1'b1};

   // Gate pattern for each state; unknown encodings fall back to both off.
   function automatic sw_t sw_enc(input state_t st);
      sw_t sw;
      case (st)
         ST_IDLE,
         ST_RECHARGE: sw = SW_CHARGE;
         ST_FIRE:     sw = SW_FIRE;
         default:     sw = SW_OFF;
      endcase
      return sw;
   endfunction

endpackage

// File: rtl/seq_dwell_timer.sv
// Loadable down-counter that times each sequencer state; expire is a
// registered flag that is high while the count sits at zero.
module seq_dwell_timer #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] value,
   output logic             expire
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value  <= '0;
         expire <= 1'b1;
      end else if (load) begin
         value  <= load_val;
         expire <= (load_val == '0);
      end else begin
         if (value != '0) value <= value - CNT_W'(1);
         expire <= (value <= CNT_W'(1));
      end
   end

endmodule

// File: rtl/pulse_switch_sequencer.sv
// Charge/discharge switch sequencer for a capacitive-discharge pulse generator
// with break-before-make dead time, fire width, recharge time and burst count.
module pulse_switch_sequencer
   import pulse_seq_pkg::*;
#(
   parameter int unsigned CNT_W   = CNT_W_DEF,
   parameter int unsigned BURST_W = BURST_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [CNT_W-1:0]   cfg_dead,
   input  logic [CNT_W-1:0]   cfg_fire,
   input  logic [CNT_W-1:0]   cfg_charge,
   input  logic [BURST_W-1:0] cfg_burst,
   output logic               s1_on,
   output logic               s2_on,
   output logic               busy,
   output logic [BURST_W-1:0] pulse_cnt,
   output logic               done,
   output logic               aborted,
   output logic               err_cfg
);

   state_t             state, state_next;
   logic [CNT_W-1:0]   sh_dead_m1, sh_fire_m1, sh_charge_m1;
   logic [BURST_W-1:0] sh_burst;
   logic               abort_pend;

   logic               tmr_load;
   logic [CNT_W-1:0]   tmr_val;
   logic [CNT_W-1:0]   tmr_value;
   logic               tmr_expire;
   logic               dwell_done;

   logic               latch, cnt_clr, cnt_inc, pend_set, pend_clr;
   logic               done_c, aborted_c, err_c;
   logic [CNT_W-1:0]   in_dead_m1, in_fire_m1, in_charge_m1;
   sw_t                sw_next;

   // Dwell reload values: zero dead/charge behave as one cycle.
   assign in_dead_m1   = (cfg_dead   == '0) ? '0 : cfg_dead   - CNT_W'(1);
   assign in_charge_m1 = (cfg_charge == '0) ? '0 : cfg_charge - CNT_W'(1);
   assign in_fire_m1   = (cfg_fire   == '0) ? '0 : cfg_fire   - CNT_W'(1);

   seq_dwell_timer #(.CNT_W(CNT_W)) u_dwell (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .value    (tmr_value),
      .expire   (tmr_expire)
   );

   // Both the registered flag and the raw count must agree before a state ends.
   assign dwell_done = tmr_expire && (tmr_value == '0);

   always_comb begin
      state_next = state;
      tmr_load   = 1'b0;
      tmr_val    = '0;
      latch      = 1'b0;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      pend_set   = 1'b0;
      pend_clr   = 1'b0;
      done_c     = 1'b0;
      aborted_c  = 1'b0;
      err_c      = 1'b0;
      case (state)
         ST_INIT: state_next = ST_IDLE;
         ST_IDLE: begin
            if (start) begin
               latch    = 1'b1;
               cnt_clr  = 1'b1;
               pend_clr = 1'b1;
               if (cfg_fire == '0 || cfg_burst == '0) begin
                  err_c = 1'b1;
               end else begin
                  state_next = ST_BREAK;
                  tmr_load   = 1'b1;
                  tmr_val    = in_dead_m1;
               end
            end
         end
         ST_BREAK, ST_FIRE, ST_RECHARGE: begin
            if (abort) begin
               state_next = ST_MAKE;
               tmr_load   = 1'b1;
               tmr_val    = sh_dead_m1;
               pend_set   = 1'b1;
            end else if (dwell_done) begin
               tmr_load = 1'b1;
               if (state == ST_BREAK) begin
                  state_next = ST_FIRE;
                  tmr_val    = sh_fire_m1;
                  cnt_inc    = 1'b1;
               end else if (state == ST_FIRE) begin
                  state_next = ST_MAKE;
                  tmr_val    = sh_dead_m1;
               end else if (pulse_cnt < sh_burst) begin
                  state_next = ST_BREAK;
                  tmr_val    = sh_dead_m1;
               end else begin
                  state_next = ST_IDLE;
                  done_c     = 1'b1;
               end
            end
         end
         ST_MAKE: begin
            if (abort) pend_set = 1'b1;
            if (dwell_done) begin
               if (abort_pend || abort) begin
                  state_next = ST_IDLE;
                  aborted_c  = 1'b1;
               end else begin
                  state_next = ST_RECHARGE;
                  tmr_load   = 1'b1;
                  tmr_val    = sh_charge_m1;
               end
            end
         end
         default: state_next = ST_INIT;
      endcase
   end

   assign sw_next = sw_enc(state_next);

   // Outputs are registered from the next state so they align with the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_INIT;
         s1_on        <= 1'b0;
         s2_on        <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         aborted      <= 1'b0;
         err_cfg      <= 1'b0;
         pulse_cnt    <= '0;
         abort_pend   <= 1'b0;
         sh_dead_m1   <= '0;
         sh_fire_m1   <= '0;
         sh_charge_m1 <= '0;
         sh_burst     <= '0;
      end else begin
         state   <= state_next;
         s1_on   <= sw_next.s1;
         s2_on   <= sw_next.s2;
         busy    <= (state_next != ST_IDLE) && (state_next != ST_INIT);
         done    <= done_c;
         aborted <= aborted_c;
         err_cfg <= err_c;
         if (latch) begin
            sh_dead_m1   <= in_dead_m1;
            sh_fire_m1   <= in_fire_m1;
            sh_charge_m1 <= in_charge_m1;
            sh_burst     <= cfg_burst;
         end
         if (cnt_clr)
            pulse_cnt <= '0;
         else if (cnt_inc && pulse_cnt != '1)
            pulse_cnt <= pulse_cnt + BURST_W'(1);
         if (pend_clr)
            abort_pend <= 1'b0;
         else if (pend_set)
            abort_pend <= 1'b1;
      end
   end

endmodule
